blockram_system_v2_leds_sequencer: RTL and testbench
====================================================

// Module: blockram_system_v2_leds_sequencer
// PURPOSE
//  Autonomous LED pattern sequencer. Avalon-MM slave CSR port (CPU side) holds up to 4 patterns,
//  a dwell period and control bits; an Avalon-MM master port drives the 4-bit LED PIO s1 slave.
//  Cycles through the patterns, writing each to PIO address 0 in turn, either looping or one-shot.
//  Sits between the Nios interconnect and the LED PIO; the CPU sets it up once, then it runs alone.
// PARAMETERS
//  LED_WIDTH   4   width of each pattern and of PIO writedata[LED_WIDTH-1:0]
//  CNT_WIDTH   24  width of PERIOD register and dwell counter
// PORTS
//  clk             in   1          system clock
//  reset_n         in   1          asynchronous active-low reset
//  address         in   3          CSR word address
//  chipselect      in   1          CSR select
//  write_n         in   1          CSR write strobe, active low
//  writedata       in   32         CSR write data
//  readdata        out  32         CSR read data, combinational (zero wait states), 0-extended
//  pio_address     out  2          to PIO s1; constant 0
//  pio_chipselect  out  1          to PIO s1
//  pio_write_n     out  1          to PIO s1, active low
//  pio_writedata   out  32         to PIO s1; {0, pattern}
// BEHAVIOUR
//  CSR map: 0 CTRL {bit0 EN, bit1 ONESHOT, bits3:2 LAST (highest slot used)}; 1 PERIOD[CNT_WIDTH-1:0];
//   2 STATUS (RO) {bit0 BUSY, bit1 DONE, bits5:4 INDEX}; 3 reads 0, writes ignored; 4..7 PATTERN0..3.
//  CSR write occurs when chipselect && !write_n; unused writedata bits ignored, unused readdata bits 0.
//  Reset: all CSRs 0, state IDLE, INDEX 0, pio_chipselect 0, pio_write_n 1, pio_writedata 0.
//  PIO master: no waitrequest; a write is pio_chipselect=1 & pio_write_n=0 for exactly the one cycle
//   the FSM is in LOAD or CLEAR; pio_writedata valid that cycle; otherwise cs=0, write_n=1.
//  FSM IDLE/LOAD/WAIT/CLEAR:
//   IDLE: EN 0->1 (CSR write with bit0=1 while IDLE) -> INDEX=0, DONE=0, next cycle LOAD.
//   LOAD: write PATTERN[INDEX]; counter <= (PERIOD==0) ? 0 : PERIOD-1; -> WAIT.
//   WAIT: counter!=0 -> decrement. counter==0: if INDEX==LAST {ONESHOT ? (DONE=1, EN=0, ->IDLE,
//    LEDs keep last pattern) : (INDEX=0, ->LOAD)} else (INDEX+1, ->LOAD).
//   CLEAR: write 0 to PIO (blank LEDs); -> IDLE.
//  Timing: CSR write enabling at edge N -> first PIO write in cycle N+1; write-to-write spacing
//   max(PERIOD,1)+1 cycles.
//  EN cleared by CPU while LOAD/WAIT: current LOAD write still completes; next state CLEAR.
//  EN written 1 while busy: ONESHOT/LAST updated, no restart; INDEX>LAST after update -> wraps/
//   terminates at end of current WAIT as if INDEX==LAST.
//  PATTERN/PERIOD writes while running: take effect at the next LOAD / next counter load.
//  CSR write in same cycle as WAIT expiry: CSR value is sampled by the following LOAD.
//  BUSY = (state != IDLE); DONE sticky until next EN 0->1 start.
//  Reset mid-sequence: immediate return to reset state; no further PIO write issued.
// TESTING
//  Reset: hold reset_n=0 mid-WAIT -> pio_chipselect=0, pio_write_n=1, all CSR reads 0.
//  P0..P3=1,2,4,8, PERIOD=3, LAST=3, EN=1 -> PIO writes 1,2,4,8,1,... every 4 cycles, first at N+1.
//  ONESHOT=1, LAST=1, P0=0xA, P1=0x5, PERIOD=0 -> writes 0xA,0x5 2 cycles apart; STATUS=0x2 after.
//  Running, write CTRL=0 -> at most one pattern write, then one write of 0, STATUS BUSY=0.
//  Running, rewrite P2=0xF during slot 1 -> next slot-2 write is 0xF; readback of addr 6 = 0xF.
//  CSR read addr 3 and write to addr 3 -> readdata 0, no state change; readdata upper bits always 0.

Source files
------------

// File: rtl/blockram_system_v2_leds_sequencer.sv
// LED pattern sequencer: CSR slave holds patterns, dwell and control;
// a small FSM replays the patterns onto the LED PIO through an Avalon master.
module blockram_system_v2_leds_sequencer #(
  parameter int LED_WIDTH = 4,
  parameter int CNT_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic                          en_q, en_d;
  logic                          oneshot_q, oneshot_d;
  logic [1:0]                    last_q, last_d;
  logic [CNT_WIDTH-1:0]          period_q, period_d;
  logic [3:0][LED_WIDTH-1:0]     pat_q, pat_d;
  logic [1:0]                    index_q, index_d;
  logic                          done_q, done_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;

  logic wr;
  logic wr_ctrl;
  logic busy;
  logic unused_wd;

  assign wr      = chipselect && !write_n;
  assign wr_ctrl = wr && (address == 3'd0);
  assign busy    = (state_q != S_IDLE);

  // Upper data bits beyond the widest CSR field carry no meaning.
  assign unused_wd = &{1'b0, writedata[31:CNT_WIDTH]};

  // All architectural state and the FSM register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      last_q    <= 2'd0;
      period_q  <= '0;
      pat_q     <= '0;
      index_q   <= 2'd0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      last_q    <= last_d;
      period_q  <= period_d;
      pat_q     <= pat_d;
      index_q   <= index_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  // Sequencing decisions, then CPU writes layered on top.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    last_d    = last_q;
    period_d  = period_q;
    pat_d     = pat_q;
    index_d   = index_q;
    done_d    = done_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          index_d = 2'd0;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = (period_q == '0) ? '0 : period_q - CNT_WIDTH'(1);
        state_d = en_q ? S_WAIT : S_CLEAR;
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_CLEAR;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else if (index_q >= last_q) begin
          index_d = 2'd0;
          if (oneshot_q) begin
            done_d  = 1'b1;
            en_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          index_d = index_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_ctrl) begin
      en_d      = writedata[0];
      oneshot_d = writedata[1];
      last_d    = writedata[3:2];
    end
    if (wr && address == 3'd1) begin
      period_d = writedata[CNT_WIDTH-1:0];
    end
    if (wr && address[2]) begin
      pat_d[address[1:0]] = writedata[LED_WIDTH-1:0];
    end
  end

  // Zero-wait CSR read mux, zero-extended.
  always_comb begin
    readdata = '0;
    unique case (address)
      3'd0: readdata[3:0] = {last_q, oneshot_q, en_q};
      3'd1: readdata[CNT_WIDTH-1:0] = period_q;
      3'd2: readdata[5:0] = {index_q, 2'b00, done_q, busy};
      3'd4, 3'd5, 3'd6, 3'd7:
        readdata[LED_WIDTH-1:0] = pat_q[address[1:0]];
      default: readdata = '0;
    endcase
  end

  // PIO write strobe lives exactly in LOAD and CLEAR.
  always_comb begin
    pio_address    = 2'd0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    unique case (1'b1)
      (state_q == S_LOAD): begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata[LED_WIDTH-1:0] = pat_q[index_q];
      end
      (state_q == S_CLEAR): begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
      end
      default: begin
        pio_chipselect = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_blockram_system_v2_leds_sequencer.sv
// Bench for the LED sequencer: directed and randomized runs
// compared against a timeline model of expected PIO writes.
module tb_blockram_system_v2_leds_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          t;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];

  always #5 clk = ~clk;

  blockram_system_v2_leds_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  // Log every PIO write with the cycle it occurred in.
  always @(negedge clk) begin
    wr_t w;
    cyc = cyc + 1;
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      w.t = cyc;
      w.d = pio_writedata;
      q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d,
                        output int st);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    st         = cyc;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() < n) chk({tag, "_timeout"}, q.size(), n);
  endtask

  // Expected write i: slot i mod (last+1), at base+1+i*(max(per,1)+1).
  task automatic check_seq(input string tag, input int base, input int per,
                           input int last, input logic [3:0] pat [4],
                           input int n);
    int sp;
    sp = ((per == 0) ? 1 : per) + 1;
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), q[i].d,
          {28'd0, pat[i % (last + 1)]});
      chk($sformatf("%s_t%0d", tag, i), q[i].t, base + 1 + i * sp);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  pat [4];
    int          st;
    int          n0;
    int          per;
    int          last;
    int          os;
    int          n;

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, pio_write_n}, 32'd1);
    chk("rst_wd", pio_writedata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), rd);
      chk($sformatf("rst_rd%0d", a), rd, 32'd0);
    end

    // Looping 1,2,4,8 with PERIOD=3.
    q.delete();
    pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4; pat[3] = 4'h8;
    for (int i = 0; i < 4; i++) csr_wr(3'(4 + i), {28'd0, pat[i]}, st);
    csr_wr(3'd1, 32'd3, st);
    csr_wr(3'd0, 32'hD, st);
    wait_writes("loop", 6, 60);
    check_seq("loop", st, 3, 3, pat, 6);
    csr_wr(3'd0, 32'd0, st);
    n0 = q.size();
    repeat (20) @(negedge clk);
    chk("dis_extra", {31'd0, (q.size() - n0 >= 1) && (q.size() - n0 <= 2)},
        32'd1);
    chk("dis_last", q[$].d, 32'd0);
    csr_rd(3'd2, rd);
    chk("dis_busy", {31'd0, rd[0]}, 32'd0);

    // One-shot A,5 with PERIOD=0.
    q.delete();
    pat[0] = 4'hA; pat[1] = 4'h5;
    csr_wr(3'd4, 32'hA, st);
    csr_wr(3'd5, 32'h5, st);
    csr_wr(3'd1, 32'd0, st);
    csr_wr(3'd0, 32'h7, st);
    wait_writes("os", 2, 40);
    repeat (20) @(negedge clk);
    chk("os_n", q.size(), 2);
    check_seq("os", st, 0, 1, pat, 2);
    csr_rd(3'd2, rd);
    chk("os_status", rd & 32'h3, 32'h2);
    csr_rd(3'd0, rd);
    chk("os_en", rd & 32'h1, 32'h0);

    // Randomized configurations, one-shot and looping.
    for (int r = 0; r < 6; r++) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin
        rd = $urandom;
        pat[i] = rd[3:0];
        csr_wr(3'(4 + i), rd, st);
      end
      per  = $urandom_range(0, 6);
      last = $urandom_range(0, 3);
      os   = $urandom_range(0, 1);
      csr_wr(3'd1, 32'(per), st);
      csr_wr(3'd0, 32'((last << 2) | (os << 1) | 1), st);
      n = os ? last + 1 : 2 * (last + 1) + 1;
      wait_writes($sformatf("rnd%0d", r), n, 200);
      if (os != 0) repeat (per + 10) @(negedge clk);
      if (os != 0) chk($sformatf("rnd%0d_n", r), q.size(), n);
      check_seq($sformatf("rnd%0d", r), st, per, last, pat, n);
      if (os == 0) begin
        csr_wr(3'd0, 32'd0, st);
        repeat (per + 10) @(negedge clk);
        chk($sformatf("rnd%0d_blank", r), q[$].d, 32'd0);
      end
      csr_rd(3'd2, rd);
      chk($sformatf("rnd%0d_st", r), rd & 32'h3, os ? 32'h2 : 32'h0);
    end

    // Pattern rewrite while running.
    q.delete();
    pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4; pat[3] = 4'h8;
    for (int i = 0; i < 4; i++) csr_wr(3'(4 + i), {28'd0, pat[i]}, st);
    csr_wr(3'd1, 32'd3, st);
    csr_wr(3'd0, 32'hD, st);
    wait_writes("rw", 2, 40);
    csr_wr(3'd6, 32'hF, st);
    wait_writes("rw", 3, 40);
    chk("rw_slot2", q[2].d, 32'hF);
    csr_rd(3'd6, rd);
    chk("rw_rd6", rd, 32'hF);
    csr_wr(3'd0, 32'd0, st);
    repeat (10) @(negedge clk);

    // Reserved address and readback widths.
    q.delete();
    csr_wr(3'd3, 32'hFFFF_FFFF, st);
    csr_rd(3'd3, rd);
    chk("a3_rd", rd, 32'd0);
    csr_wr(3'd1, 32'hFFFF_FFFF, st);
    csr_rd(3'd1, rd);
    chk("per_w", rd, 32'h00FF_FFFF);
    csr_wr(3'd0, 32'hFFFF_FFFE, st);
    csr_rd(3'd0, rd);
    chk("ctrl_w", rd, 32'hE);
    csr_wr(3'd4, 32'hFFFF_FFFF, st);
    csr_rd(3'd4, rd);
    chk("pat_w", rd, 32'hF);
    repeat (5) @(negedge clk);
    chk("a3_nowr", q.size(), 0);
    csr_rd(3'd2, rd);
    chk("a3_busy", rd & 32'h1, 32'h0);

    // Reset during a long dwell.
    q.delete();
    csr_wr(3'd1, 32'd1000, st);
    csr_wr(3'd0, 32'h1, st);
    wait_writes("rst", 1, 20);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("mrst_wn", {31'd0, pio_write_n}, 32'd1);
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), rd);
      chk($sformatf("mrst_rd%0d", a), rd, 32'd0);
    end
    n0 = q.size();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mrst_nowr", q.size(), n0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
